// File: rtl/ex_md_stage.sv
// Execute-stage M-extension unit: operand forwarding, iterative shift-add multiply /
// restoring divide with pipeline stall, and result muxing onto the EX result bus.
module ex_md_stage #(
  parameter int XLEN          = 32,
  parameter bit FAST_MUL      = 1'b0,
  parameter bit DIV_EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            md_valid_i,
  input  logic [2:0]      md_op_i,
  input  logic [1:0]      forwardA,
  input  logic [1:0]      forwardB,
  input  logic [XLEN-1:0] Rs1_data_ex_i,
  input  logic [XLEN-1:0] Rs2_data_ex_i,
  input  logic [XLEN-1:0] result_ex_mem_o,
  input  logic [XLEN-1:0] load_or_result_mem_wb_o,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] A_o,
  output logic [XLEN-1:0] B_o,
  output logic            md_busy_o,
  output logic            md_done_o,
  output logic [XLEN-1:0] result_ex_o
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   md_result_q, md_result_d;

  logic              issue, is_div, a_sgn, b_sgn, neg_a, neg_b, b_zero, ovf, special;
  logic [XLEN-1:0]   a_mag, b_mag, early_res;
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
  logic [2*XLEN-1:0] acc_step;

  // MUL keeps the low half of the unsigned product, which equals the signed one.
  function automatic logic [XLEN-1:0] mul_sel(input logic [2*XLEN-1:0] prod,
                                              input logic neg, input logic [2:0] op);
    logic [2*XLEN-1:0] p;
    p = neg ? -prod : prod;
    return (op[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] div_sel(input logic [XLEN-1:0] q, input logic [XLEN-1:0] r,
                                              input logic negq, input logic negr,
                                              input logic [2:0] op);
    if (op[1]) return negr ? -r : r;
    return negq ? -q : q;
  endfunction

  always_comb begin
    unique case (forwardA)
      2'b10:   A_o = result_ex_mem_o;
      2'b01:   A_o = load_or_result_mem_wb_o;
      default: A_o = Rs1_data_ex_i;
    endcase
    unique case (forwardB)
      2'b10:   B_o = result_ex_mem_o;
      2'b01:   B_o = load_or_result_mem_wb_o;
      default: B_o = Rs2_data_ex_i;
    endcase
  end

  always_comb begin
    issue  = (state_q == IDLE) && md_valid_i && !flush_i;
    is_div = md_op_i[2];
    a_sgn  = is_div ? ~md_op_i[0] : (md_op_i[1:0] == 2'b01 || md_op_i[1:0] == 2'b10);
    b_sgn  = is_div ? ~md_op_i[0] : (md_op_i[1:0] == 2'b01);
    neg_a  = a_sgn & A_o[XLEN-1];
    neg_b  = b_sgn & B_o[XLEN-1];
    a_mag  = neg_a ? -A_o : A_o;
    b_mag  = neg_b ? -B_o : B_o;
    b_zero = (B_o == '0);
    ovf    = is_div && !md_op_i[0] && (A_o == {1'b1, {(XLEN-1){1'b0}}}) && (&B_o);
    special = is_div && (b_zero || ovf);
    if (b_zero) early_res = md_op_i[1] ? A_o : '1;
    else        early_res = md_op_i[1] ? '0 : A_o;
    fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
  end

  // One iteration: multiply adds the multiplicand into the upper half and shifts right;
  // divide shifts {rem,quot} left and keeps the trial subtraction when it does not borrow.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, opb_q};
    if (op_q[2]) begin
      if (rem_diff[XLEN]) acc_step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else                acc_step = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (issue) begin
        if (DIV_EARLY_OUT && special)   state_d = DONE;
        else if (FAST_MUL && !is_div)   state_d = DONE;
        else                            state_d = BUSY;
      end
      BUSY:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // Divide by zero yields all-ones / dividend naturally only if the quotient is not negated.
  always_comb begin
    cnt_d       = cnt_q;
    op_d        = op_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    opb_d       = opb_q;
    acc_d       = acc_q;
    md_result_d = md_result_q;
    if (issue) begin
      op_d   = md_op_i;
      negq_d = (neg_a ^ neg_b) & ~(is_div & b_zero);
      negr_d = neg_a;
      opb_d  = is_div ? b_mag : a_mag;
      acc_d  = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
      cnt_d  = CW'(XLEN - 1);
      if (DIV_EARLY_OUT && special)  md_result_d = early_res;
      else if (FAST_MUL && !is_div)  md_result_d = mul_sel(fast_prod, neg_a ^ neg_b, md_op_i);
    end else if (state_q == BUSY && !flush_i) begin
      acc_d = acc_step;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        if (op_q[2]) md_result_d = div_sel(acc_step[XLEN-1:0], acc_step[2*XLEN-1:XLEN],
                                           negq_q, negr_q, op_q);
        else         md_result_d = mul_sel(acc_step, negq_q, op_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      op_q        <= '0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      opb_q       <= '0;
      acc_q       <= '0;
      md_result_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
      opb_q       <= opb_d;
      acc_q       <= acc_d;
      md_result_q <= md_result_d;
    end
  end

  always_comb begin
    md_busy_o   = issue || (state_q == BUSY);
    md_done_o   = (state_q == DONE);
    result_ex_o = md_done_o ? md_result_q : alu_result_i;
  end

endmodule

// File: tb/tb_ex_md_stage.sv
// Directed bench for ex_md_stage: one iterative/early-out instance and one fast-multiply
// instance without early-out share operands but have separate issue strobes.
module tb_ex_md_stage;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            md_valid1, md_valid2;
  logic [2:0]      md_op;
  logic [1:0]      fwdA, fwdB;
  logic [XLEN-1:0] rs1, rs2, exmem, memwb, alu;
  logic            flush;
  logic [XLEN-1:0] a1, b1, res1, a2, b2, res2;
  logic            busy1, done1, busy2, done2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_md_stage #(.XLEN(XLEN), .FAST_MUL(1'b0), .DIV_EARLY_OUT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .md_valid_i(md_valid1), .md_op_i(md_op),
    .forwardA(fwdA), .forwardB(fwdB), .Rs1_data_ex_i(rs1), .Rs2_data_ex_i(rs2),
    .result_ex_mem_o(exmem), .load_or_result_mem_wb_o(memwb), .alu_result_i(alu),
    .flush_i(flush), .A_o(a1), .B_o(b1), .md_busy_o(busy1), .md_done_o(done1),
    .result_ex_o(res1));

  ex_md_stage #(.XLEN(XLEN), .FAST_MUL(1'b1), .DIV_EARLY_OUT(1'b0)) dut_fast (
    .clk(clk), .rst_n(rst_n), .md_valid_i(md_valid2), .md_op_i(md_op),
    .forwardA(fwdA), .forwardB(fwdB), .Rs1_data_ex_i(rs1), .Rs2_data_ex_i(rs2),
    .result_ex_mem_o(exmem), .load_or_result_mem_wb_o(memwb), .alu_result_i(alu),
    .flush_i(flush), .A_o(a2), .B_o(b2), .md_busy_o(busy2), .md_done_o(done2),
    .result_ex_o(res2));

  // Called just after a rising edge; that cycle is the issue cycle (lat 0).
  task automatic do_op(input bit which, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int lat, output int nbusy,
                       output logic [31:0] res);
    md_op = op; rs1 = a; rs2 = b; fwdA = 2'b00; fwdB = 2'b00; flush = 1'b0;
    if (which) md_valid2 = 1'b1; else md_valid1 = 1'b1;
    lat = -1; nbusy = 0; res = 'x;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if ((which ? done2 : done1) === 1'b1) begin
        lat = k; res = which ? res2 : res1;
        break;
      end
      if ((which ? busy2 : busy1) === 1'b1) nbusy++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    md_valid1 = 1'b0; md_valid2 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; md_valid1 = 1'b0; md_valid2 = 1'b0; md_op = 3'd0; fwdA = 2'b00; fwdB = 2'b00;
    rs1 = '0; rs2 = '0; exmem = '0; memwb = '0; alu = 32'h1234_5678; flush = 1'b0;
    #7;
    n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy1); end
    n_tests++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done1); end
    n_tests++; if (res1 !== 32'h1234_5678) begin n_fail++; $display("FAIL reset_result got %h exp 12345678", res1); end
    n_tests++; if (done2 !== 1'b0) begin n_fail++; $display("FAIL reset_done_fast got %b exp 0", done2); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got %b exp 0", busy1); end
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    logic [31:0] ea, eb;
    rs1 = 32'h1111_1111; rs2 = 32'h2222_2222; exmem = 32'h3333_3333; memwb = 32'h4444_4444;
    for (int f = 0; f < 4; f++) begin
      fwdA = f[1:0]; fwdB = 2'(3 - f); alu = 32'hA000_0000 + f;
      @(negedge clk);
      ea = (f == 2) ? 32'h3333_3333 : (f == 1) ? 32'h4444_4444 : 32'h1111_1111;
      eb = (f == 1) ? 32'h3333_3333 : (f == 2) ? 32'h4444_4444 : 32'h2222_2222;
      n_tests++; if (a1 !== ea) begin n_fail++; $display("FAIL fwdA_%0d got %h exp %h", f, a1, ea); end
      n_tests++; if (b1 !== eb) begin n_fail++; $display("FAIL fwdB_%0d got %h exp %h", f, b1, eb); end
      n_tests++; if (a2 !== ea) begin n_fail++; $display("FAIL fwdA_fast_%0d got %h exp %h", f, a2, ea); end
      n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL nonm_busy_%0d got %b exp 0", f, busy1); end
      n_tests++; if (res1 !== 32'hA000_0000 + f) begin n_fail++; $display("FAIL alu_pass_%0d got %h exp %h", f, res1, 32'hA000_0000 + f); end
      @(posedge clk); #1;
    end
    fwdA = 2'b00; fwdB = 2'b00;
  endtask

  task automatic test_mul_iter();
    int lat, nb; logic [31:0] r;
    do_op(1'b0, 3'd0, 32'd7, 32'hFFFF_FFFD, lat, nb, r);
    n_tests++; if (r !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_res got %h exp ffffffeb", r); end
    n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL mul_lat got %0d exp 33", lat); end
    n_tests++; if (nb !== 33) begin n_fail++; $display("FAIL mul_busy_cycles got %0d exp 33", nb); end
    do_op(1'b0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, nb, r);
    n_tests++; if (r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu_res got %h exp fffffffe", r); end
    do_op(1'b0, 3'd2, 32'hFFFF_FFFF, 32'd2, lat, nb, r);
    n_tests++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulhsu_res got %h exp ffffffff", r); end
    do_op(1'b0, 3'd1, 32'hFFFF_FFFD, 32'd7, lat, nb, r);
    n_tests++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulh_res got %h exp ffffffff", r); end
  endtask

  task automatic test_fast_mul();
    int lat, nb; logic [31:0] r;
    do_op(1'b1, 3'd0, 32'd7, 32'hFFFF_FFFD, lat, nb, r);
    n_tests++; if (r !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL fmul_res got %h exp ffffffeb", r); end
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL fmul_lat got %0d exp 1", lat); end
    n_tests++; if (nb !== 1) begin n_fail++; $display("FAIL fmul_busy_cycles got %0d exp 1", nb); end
    do_op(1'b1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, nb, r);
    n_tests++; if (r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL fmulhu_res got %h exp fffffffe", r); end
    do_op(1'b1, 3'd2, 32'hFFFF_FFFF, 32'd2, lat, nb, r);
    n_tests++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL fmulhsu_res got %h exp ffffffff", r); end
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL fmulhsu_lat got %0d exp 1", lat); end
  endtask

  task automatic test_div_special();
    int lat, nb; logic [31:0] r;
    do_op(1'b0, 3'd4, 32'd5, 32'd0, lat, nb, r);
    n_tests++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_res got %h exp ffffffff", r); end
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL div0_lat got %0d exp 1", lat); end
    do_op(1'b0, 3'd7, 32'd5, 32'd0, lat, nb, r);
    n_tests++; if (r !== 32'd5) begin n_fail++; $display("FAIL remu0_res got %h exp 5", r); end
    do_op(1'b0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, lat, nb, r);
    n_tests++; if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL divovf_res got %h exp 80000000", r); end
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL divovf_lat got %0d exp 1", lat); end
    do_op(1'b0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, lat, nb, r);
    n_tests++; if (r !== 32'd0) begin n_fail++; $display("FAIL removf_res got %h exp 0", r); end
    do_op(1'b1, 3'd4, 32'hFFFF_FFFA, 32'd0, lat, nb, r);
    n_tests++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL it_div0_res got %h exp ffffffff", r); end
    n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL it_div0_lat got %0d exp 33", lat); end
    do_op(1'b1, 3'd6, 32'hFFFF_FFFA, 32'd0, lat, nb, r);
    n_tests++; if (r !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL it_rem0_res got %h exp fffffffa", r); end
    do_op(1'b1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, lat, nb, r);
    n_tests++; if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL it_divovf_res got %h exp 80000000", r); end
    do_op(1'b1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, lat, nb, r);
    n_tests++; if (r !== 32'd0) begin n_fail++; $display("FAIL it_removf_res got %h exp 0", r); end
  endtask

  task automatic test_div_signed();
    int lat, nb; logic [31:0] r;
    do_op(1'b0, 3'd6, 32'hFFFF_FFF9, 32'd2, lat, nb, r);
    n_tests++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_neg_res got %h exp ffffffff", r); end
    n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL rem_neg_lat got %0d exp 33", lat); end
    do_op(1'b0, 3'd4, 32'hFFFF_FFF9, 32'd2, lat, nb, r);
    n_tests++; if (r !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_res got %h exp fffffffd", r); end
    do_op(1'b0, 3'd4, 32'd7, 32'hFFFF_FFFE, lat, nb, r);
    n_tests++; if (r !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_negdiv_res got %h exp fffffffd", r); end
    do_op(1'b0, 3'd6, 32'd7, 32'hFFFF_FFFE, lat, nb, r);
    n_tests++; if (r !== 32'd1) begin n_fail++; $display("FAIL rem_negdiv_res got %h exp 1", r); end
  endtask

  task automatic test_fwd_latch();
    logic [31:0] r; bit seen;
    md_op = 3'd4; fwdA = 2'b10; fwdB = 2'b00; exmem = 32'hFFFF_FFF9; rs1 = 32'd0; rs2 = 32'd2;
    md_valid1 = 1'b1; seen = 1'b0; r = 'x;
    @(posedge clk); #1; exmem = 32'h0000_0100; rs2 = 32'd9;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done1 === 1'b1) begin seen = 1'b1; r = res1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1; md_valid1 = 1'b0; fwdA = 2'b00;
    n_tests++; if (!seen) begin n_fail++; $display("FAIL fwd_latch_done got 0 exp 1"); end
    n_tests++; if (r !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL fwd_latch_res got %h exp fffffffd", r); end
  endtask

  task automatic test_flush();
    bit saw;
    md_op = 3'd5; rs1 = 32'd100; rs2 = 32'd7; alu = 32'h0BAD_F00D; md_valid1 = 1'b1;
    repeat (10) @(posedge clk);
    #1; flush = 1'b1;
    @(negedge clk);
    n_tests++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before got %b exp 1", busy1); end
    @(posedge clk); #1; flush = 1'b0; md_valid1 = 1'b0;
    @(negedge clk);
    n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL flush_busy_after got %b exp 0", busy1); end
    saw = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done1 === 1'b1) saw = 1'b1;
      @(negedge clk);
    end
    n_tests++; if (saw !== 1'b0) begin n_fail++; $display("FAIL flush_no_done got %b exp 0", saw); end
    n_tests++; if (res1 !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL flush_result got %h exp 0badf00d", res1); end
    @(posedge clk); #1; md_valid1 = 1'b1; flush = 1'b1; #1;
    n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL flush_issue_busy got %b exp 0", busy1); end
    @(posedge clk); #1; md_valid1 = 1'b0; flush = 1'b0;
    @(negedge clk);
    n_tests++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin n_fail++; $display("FAIL flush_issue_blocked got %b%b exp 00", busy1, done1); end
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mid();
    int lat, nb; logic [31:0] r;
    md_op = 3'd0; rs1 = 32'd7; rs2 = 32'd3; alu = 32'd0; md_valid1 = 1'b1;
    repeat (5) @(posedge clk);
    #2; md_valid1 = 1'b0;
    #0 n_tests++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before got %b exp 1", busy1); end
    rst_n = 1'b0; #1;
    n_tests++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl got %b%b exp 00", busy1, done1); end
    n_tests++; if (res1 !== 32'd0) begin n_fail++; $display("FAIL rstmid_result got %h exp 0", res1); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got %b exp 0", busy1); end
    @(posedge clk); #1;
    do_op(1'b0, 3'd0, 32'd7, 32'd3, lat, nb, r);
    n_tests++; if (r !== 32'd21) begin n_fail++; $display("FAIL rstmid_next_res got %h exp 15", r); end
  endtask

  task automatic test_back_to_back();
    int lat, nb; logic [31:0] r;
    do_op(1'b0, 3'd5, 32'd100, 32'd7, lat, nb, r);
    n_tests++; if (r !== 32'd14) begin n_fail++; $display("FAIL b2b_divu_res got %h exp e", r); end
    do_op(1'b0, 3'd7, 32'd100, 32'd7, lat, nb, r);
    n_tests++; if (r !== 32'd2) begin n_fail++; $display("FAIL b2b_remu_res got %h exp 2", r); end
    n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_lat got %0d exp 33", lat); end
    n_tests++; if (nb !== 33) begin n_fail++; $display("FAIL b2b_busy_cycles got %0d exp 33", nb); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_mul_iter();
    test_fast_mul();
    test_div_special();
    test_div_signed();
    test_fwd_latch();
    test_flush();
    test_rst_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_md_stage.md
Name: ex_md_stage

Overview:
- Parametrised execute stage for the five-stage RISC-V pipeline that adds the RV32M/RV64M multiply/divide path beside the existing single-cycle ALU.
- Performs the EX-stage operand forwarding selection and latches the forwarded operands at issue.
- Runs an iterative shift-add multiplier / restoring divider FSM and stalls the pipeline until the result is ready.
- Muxes the M-extension result onto the EX result bus; flushes abort an in-flight operation.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- FAST_MUL, 0, 1 = multiply is single-pass combinational (one stall cycle); 0 = iterative multiply.
- DIV_EARLY_OUT, 1, 1 = divide-by-zero and signed overflow complete without iterating.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- md_valid_i  in  1  ID/EX holds an M-extension instruction
- md_op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- forwardA  in  2  operand A select: 2'b10 EX/MEM, 2'b01 MEM/WB, otherwise register file
- forwardB  in  2  operand B select, same encoding as forwardA
- Rs1_data_ex_i  in  XLEN  register-file operand 1
- Rs2_data_ex_i  in  XLEN  register-file operand 2
- result_ex_mem_o  in  XLEN  EX/MEM forwarded value
- load_or_result_mem_wb_o  in  XLEN  MEM/WB forwarded value
- alu_result_i  in  XLEN  existing ALU result
- flush_i  in  1  pipeline flush
- A_o  out  XLEN  forwarded operand A, also feeds the ALU
- B_o  out  XLEN  forwarded operand B, also feeds the ALU and the store path
- md_busy_o  out  1  stall request, ORed into PL_stall
- md_done_o  out  1  one-cycle pulse: M result valid
- result_ex_o  out  XLEN  EX result bus

Behaviour:
- Forwarding: A_o/B_o are combinational 3-way muxes of the inputs above per forwardA/forwardB.
- Reset (async, rst_n=0): state=IDLE; the count, operand and product/remainder registers, and md_result are cleared to 0. md_busy_o=0, md_done_o=0.
- result_ex_o: after reset it tracks alu_result_i, since md_done_o=0.
- States:
  - IDLE: md_valid_i=1 and flush_i=0 issue the op. Magnitudes of A_o/B_o are latched with sign flags (signed per op; MULHSU treats only rs1 as signed). Next state:
    - DONE if DIV_EARLY_OUT and the op is a special case;
    - DONE if FAST_MUL and the op is a multiply;
    - otherwise BUSY with count=XLEN-1.
  - BUSY: one bit per cycle. The multiply adds and shifts a 2*XLEN accumulator. The divide is restoring: shift the remainder, subtract, set the quotient bit. At count==0, apply sign fixup into md_result → DONE; otherwise count-1.
  - DONE: md_done_o=1 and result_ex_o=md_result. md_valid_i is ignored (same instruction still held). Next state is unconditionally IDLE.
- md_busy_o = (IDLE & md_valid_i & ~flush_i) | BUSY, combinational, so the issue cycle stalls. It is 0 in DONE, so the pipeline advances at the end of DONE.
- Latency from issue cycle T:
  - iterative: BUSY T+1..T+XLEN, DONE T+XLEN+1;
  - fast/special: DONE T+1.
- Operands are latched at T. Later changes on the forwarding inputs have no effect.
- Result selection:
  - MUL: low XLEN bits of the product. MULH/MULHSU/MULHU: high XLEN bits.
  - DIV/DIVU: quotient. REM/REMU: remainder.
  - Remainder takes the sign of the dividend. Quotient is negated when the operand signs differ.
- Special cases, identical with or without early-out:
  - divisor 0: quotient all-ones, remainder = dividend.
  - signed -2^(XLEN-1) / -1: quotient = dividend, remainder 0.
- result_ex_o = md_result when DONE, else alu_result_i.
- Flush: flush_i=1 in any state → IDLE next cycle. md_done_o is not asserted, the partial result is discarded and md_result is held. A flush in the issue cycle blocks the issue.
- Reset mid-operation: immediate return to IDLE; no result is produced.
- Back-to-back M ops: the second issues in the first IDLE cycle after DONE; there is no dead cycle beyond the pipeline advance.

Test Plan:
- MUL, XLEN=32, FAST_MUL=0, A=7, B=0xFFFFFFFD → md_busy_o high for cycles T..T+32, md_done_o at T+33, result_ex_o=0xFFFFFFEB.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF; FAST_MUL=1 → done at T+1.
- DIV 5/0 → 0xFFFFFFFF, REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0; with DIV_EARLY_OUT=1 both done at T+1.
- REM -7/2 → 0xFFFFFFFF; DIV -7/2 → 0xFFFFFFFD; operand via forwardA=2'b10 latched, then result_ex_mem_o changed during BUSY → result unchanged.
- flush_i pulsed at T+10 of a DIVU → IDLE at T+11, no md_done_o, md_busy_o=0; rst_n low mid-MUL → all outputs 0 asynchronously.
- Non-M instruction (md_valid_i=0) → md_busy_o=0, result_ex_o=alu_result_i, A_o/B_o follow forward selects each cycle.
